// File: rtl/switch_debouncer.sv
// Switch conditioning: per-channel synchroniser and stability-counter debouncer with
// registered press/release pulses and a record of the most recent press.
module switch_debouncer #(
    parameter int unsigned NUM_INPUTS      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned SYNC_STAGES     = 2,
    localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_INPUTS-1:0] raw_i,
    output logic [NUM_INPUTS-1:0] level_o,
    output logic [NUM_INPUTS-1:0] press_o,
    output logic [NUM_INPUTS-1:0] release_o,
    output logic                  any_press_o,
    output logic [IdxW-1:0]       last_idx_o,
    output logic                  last_valid_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] synced;
    logic [CntW-1:0]       cnt_q  [NUM_INPUTS];
    logic [CntW-1:0]       cnt_d  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] level_q, level_d;
    logic [NUM_INPUTS-1:0] press_q, press_d;
    logic [NUM_INPUTS-1:0] release_q, release_d;
    logic                  any_press_q;
    logic [IdxW-1:0]       last_idx_q, last_idx_d;
    logic                  last_valid_q;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i]   = synced[i];
                    press_d[i]   = synced[i];
                    release_d[i] = ~synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Descending scan so the lowest pressed index wins.
    always_comb begin
        last_idx_d = last_idx_q;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                last_idx_d = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            level_q      <= '0;
            press_q      <= '0;
            release_q    <= '0;
            any_press_q  <= 1'b0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            any_press_q  <= |press_d;
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_q | (|press_q);
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign any_press_o  = any_press_q;
    assign last_idx_o   = last_idx_q;
    assign last_valid_o = last_valid_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios on a DEBOUNCE_CYCLES=4 and a
// DEBOUNCE_CYCLES=1 instance, then random stimulus against a sample-window model.
module tb_switch_debouncer;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] raw4, raw1;
    logic [15:0] lvl4, prs4, rel4, lvl1, prs1, rel1;
    logic        any4, vld4, any1, vld1;
    logic [3:0]  idx4, idx1;

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 tracks the 4-cycle instance, index 1 the 1-cycle instance.
    logic [15:0] m_lvl [2];
    logic [15:0] m_prs [2];
    logic [15:0] m_rel [2];
    logic        m_any [2];
    logic        m_vld [2];
    logic [3:0]  m_idx [2];
    logic [31:0] samp [$];
    int          n;

    always #5 clk = ~clk;

    switch_debouncer #(.NUM_INPUTS(16), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(SYNC)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(raw4), .level_o(lvl4), .press_o(prs4),
        .release_o(rel4), .any_press_o(any4), .last_idx_o(idx4), .last_valid_o(vld4)
    );

    switch_debouncer #(.NUM_INPUTS(16), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(SYNC)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(raw1), .level_o(lvl1), .press_o(prs1),
        .release_o(rel1), .any_press_o(any1), .last_idx_o(idx1), .last_valid_o(vld1)
    );

    // Value the debouncer compares at non-reset edge j: raw sampled SYNC edges earlier.
    function automatic logic [15:0] synced_at(int d, int j);
        logic [31:0] e;
        if (j - 1 - SYNC < 0) return 16'h0;
        e = samp[j - 1 - SYNC];
        return (d == 0) ? e[15:0] : e[31:16];
    endfunction

    // Level flips when the last DC compared samples all disagree with it.
    task automatic model_edge();
        if (!rst_n) begin
            n = 0;
            samp.delete();
            for (int d = 0; d < 2; d++) begin
                m_lvl[d] = '0; m_prs[d] = '0; m_rel[d] = '0;
                m_any[d] = 1'b0; m_vld[d] = 1'b0; m_idx[d] = '0;
            end
        end else begin
            samp.push_back({raw1, raw4});
            n++;
            for (int d = 0; d < 2; d++) begin
                int dc;
                dc = (d == 0) ? 4 : 1;
                if (m_prs[d] != 0) begin
                    m_vld[d] = 1'b1;
                    for (int c = 15; c >= 0; c--) if (m_prs[d][c]) m_idx[d] = 4'(c);
                end
                m_prs[d] = '0;
                m_rel[d] = '0;
                for (int c = 0; c < 16; c++) begin
                    logic flip;
                    flip = (n >= dc);
                    for (int j = n - dc + 1; j <= n && flip; j++) begin
                        logic [15:0] s;
                        s = synced_at(d, j);
                        if (s[c] == m_lvl[d][c]) flip = 1'b0;
                    end
                    if (flip) begin
                        m_lvl[d][c] = ~m_lvl[d][c];
                        if (m_lvl[d][c]) m_prs[d][c] = 1'b1;
                        else m_rel[d][c] = 1'b1;
                    end
                end
                m_any[d] = |m_prs[d];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw4  = '0;
        raw1  = '0;
        for (int t = 0; t < 3; t++) tick();
        checks++;
        if ({lvl4, prs4, rel4, any4, idx4, vld4} !== 54'h0) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=0", {lvl4, prs4, rel4, any4, idx4, vld4});
        end
        checks++;
        if ({lvl1, prs1, rel1, any1, idx1, vld1} !== 54'h0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=0", {lvl1, prs1, rel1, any1, idx1, vld1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_step();
        raw4[3] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (lvl4[3] !== (t >= 6)) begin
                failures++;
                $display("FAIL step_level t=%0d got=%b exp=%b", t, lvl4[3], t >= 6);
            end
            checks++;
            if (prs4 !== ((t == 6) ? 16'h0008 : 16'h0000)) begin
                failures++;
                $display("FAIL step_press t=%0d got=%h", t, prs4);
            end
            checks++;
            if (any4 !== (t == 6)) begin
                failures++;
                $display("FAIL step_any t=%0d got=%b exp=%b", t, any4, t == 6);
            end
            checks++;
            if ({vld4, idx4} !== ((t >= 7) ? 5'h13 : 5'h00)) begin
                failures++;
                $display("FAIL step_last t=%0d got=%h exp=%h", t, {vld4, idx4},
                         (t >= 7) ? 5'h13 : 5'h00);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [8];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int t = 1; t <= 14; t++) begin
            raw4[5] = (t <= 8) ? pat[t-1] : 1'b1;
            tick();
            checks++;
            if (prs4[5] !== (t == 10) || lvl4[5] !== (t >= 10)) begin
                failures++;
                $display("FAIL bounce_press t=%0d got=%b/%b exp=%b/%b", t, prs4[5], lvl4[5],
                         t == 10, t >= 10);
            end
            checks++;
            if (idx4 !== ((t >= 11) ? 4'd5 : 4'd3) || rel4 !== 16'h0) begin
                failures++;
                $display("FAIL bounce_idx t=%0d got=%0d rel=%h", t, idx4, rel4);
            end
        end
    endtask

    task automatic test_simultaneous();
        raw4[2] = 1'b1;
        raw4[9] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (prs4 !== ((t == 6) ? 16'h0204 : 16'h0000)) begin
                failures++;
                $display("FAIL simul_press t=%0d got=%h", t, prs4);
            end
            checks++;
            if (idx4 !== ((t >= 7) ? 4'd2 : 4'd5)) begin
                failures++;
                $display("FAIL simul_idx t=%0d got=%0d exp=%0d", t, idx4, (t >= 7) ? 2 : 5);
            end
        end
    endtask

    task automatic test_release();
        raw4[7] = 1'b1;
        for (int t = 1; t <= 8; t++) tick();
        checks++;
        if (lvl4[7] !== 1'b1 || idx4 !== 4'd7) begin
            failures++;
            $display("FAIL release_setup got=%b/%0d exp=1/7", lvl4[7], idx4);
        end
        raw4[7] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (rel4 !== ((t == 6) ? 16'h0080 : 16'h0000) || lvl4[7] !== (t < 6)) begin
                failures++;
                $display("FAIL release_pulse t=%0d got=%h lvl=%b", t, rel4, lvl4[7]);
            end
            checks++;
            if (prs4 !== 16'h0 || any4 !== 1'b0 || idx4 !== 4'd7) begin
                failures++;
                $display("FAIL release_quiet t=%0d press=%h any=%b idx=%0d", t, prs4, any4, idx4);
            end
        end
    endtask

    task automatic test_reset_mid();
        raw4[0] = 1'b1;
        for (int t = 1; t <= 8; t++) tick();
        checks++;
        if (lvl4[0] !== 1'b1 || idx4 !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_setup got=%b/%0d exp=1/0", lvl4[0], idx4);
        end
        rst_n = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++;
            if ({lvl4, prs4, rel4, any4, idx4, vld4, lvl1, vld1} !== 56'h0) begin
                failures++;
                $display("FAIL rstmid_clear t=%0d got=%h", t, {lvl4, prs4, rel4, any4, idx4, vld4});
            end
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (prs4 !== ((t == 6) ? 16'h022D : 16'h0000) || lvl4[0] !== (t >= 6)) begin
                failures++;
                $display("FAIL rstmid_press t=%0d got=%h lvl=%b", t, prs4, lvl4[0]);
            end
            checks++;
            if (vld4 !== (t >= 7) || idx4 !== 4'd0) begin
                failures++;
                $display("FAIL rstmid_last t=%0d got=%b/%0d exp=%b/0", t, vld4, idx4, t >= 7);
            end
        end
    endtask

    function automatic logic vfn(int t);
        if (t <= 0) return 1'b0;
        return (((t - 1) >> 1) & 1) == 0;
    endfunction

    task automatic test_fast_d1();
        for (int t = 1; t <= 20; t++) begin
            raw1[1] = vfn(t);
            tick();
            checks++;
            if (lvl1[1] !== vfn(t - 2)) begin
                failures++;
                $display("FAIL d1_level t=%0d got=%b exp=%b", t, lvl1[1], vfn(t - 2));
            end
            checks++;
            if (prs1 !== {14'h0, vfn(t - 2) & ~vfn(t - 3), 1'b0} ||
                rel1 !== {14'h0, ~vfn(t - 2) & vfn(t - 3), 1'b0}) begin
                failures++;
                $display("FAIL d1_pulse t=%0d press=%h release=%h", t, prs1, rel1);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 16; c++) begin
                if ($urandom_range(7) == 0) raw4[c] = ~raw4[c];
                if ($urandom_range(2) == 0) raw1[c] = ~raw1[c];
            end
            rst_n = !(cyc >= 300 && cyc < 302);
            tick();
            checks++;
            if (lvl4 !== m_lvl[0] || lvl1 !== m_lvl[1]) begin
                failures++;
                $display("FAIL rnd_level cyc=%0d got=%h/%h exp=%h/%h", cyc, lvl4, lvl1,
                         m_lvl[0], m_lvl[1]);
            end
            checks++;
            if (prs4 !== m_prs[0] || prs1 !== m_prs[1]) begin
                failures++;
                $display("FAIL rnd_press cyc=%0d got=%h/%h exp=%h/%h", cyc, prs4, prs1,
                         m_prs[0], m_prs[1]);
            end
            checks++;
            if (rel4 !== m_rel[0] || rel1 !== m_rel[1]) begin
                failures++;
                $display("FAIL rnd_release cyc=%0d got=%h/%h exp=%h/%h", cyc, rel4, rel1,
                         m_rel[0], m_rel[1]);
            end
            checks++;
            if (any4 !== m_any[0] || any1 !== m_any[1]) begin
                failures++;
                $display("FAIL rnd_any cyc=%0d got=%b/%b exp=%b/%b", cyc, any4, any1,
                         m_any[0], m_any[1]);
            end
            checks++;
            if ({vld4, idx4} !== {m_vld[0], m_idx[0]} || {vld1, idx1} !== {m_vld[1], m_idx[1]})
            begin
                failures++;
                $display("FAIL rnd_last cyc=%0d got=%h/%h exp=%h/%h", cyc, {vld4, idx4},
                         {vld1, idx1}, {m_vld[0], m_idx[0]}, {m_vld[1], m_idx[1]});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw4  = '0;
        raw1  = '0;
        n     = 0;
        test_reset();
        test_step();
        test_bounce();
        test_simultaneous();
        test_release();
        test_reset_mid();
        test_fast_d1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
